demux32_1to2_buf: RTL and testbench
===================================

Name: demux32_1to2_buf

Overview:
- Registered 1-to-2 demultiplexer for 32-bit words; the steering counterpart to the 2:1 word mux.
- Accepts one word per cycle on a valid/ready input and routes it by a sel bit into one of two per-destination FIFOs (A for sel=0, B for sel=1).
- Each destination drains independently through its own valid/ready port.
- Sits between a producer stage and two consumers, e.g. splitting a write stream between data memory and an I/O path, so one stalled consumer does not block the other until its buffer fills.

Parameters:
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- AW, 1, pointer width; equals log2(DEPTH).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset; asserted when 0.
- inData  input  32  word to steer.
- inSel  input  1  destination select; 0 selects A, 1 selects B. Must be stable while inValid=1.
- inValid  input  1  producer has a word.
- inReady  output  1  block accepts the word this cycle.
- outA  output  32  head word of FIFO A.
- outAValid  output  1  FIFO A is non-empty.
- outAReady  input  1  consumer A takes the head this cycle.
- outB  output  32  head word of FIFO B.
- outBValid  output  1  FIFO B is non-empty.
- outBReady  input  1  consumer B takes the head this cycle.

Behaviour:
- Reset (Reset=0, asynchronous):
  - counts, read pointers and write pointers go to 0.
  - outAValid=0, outBValid=0.
  - all storage entries cleared, so outA=outB=0.
  - Reset mid-transfer discards all buffered words. No transfer completes on the releasing edge.
- inReady is combinational:
  - inSel=0: inReady = (countA != DEPTH).
  - inSel=1: inReady = (countB != DEPTH).
  - inReady depends only on registered counts and inSel, never on outXReady. There is no pass-through when full.
- Push: inValid & inReady at a rising edge.
  - Writes inData to the selected FIFO at its write pointer.
  - The write pointer increments modulo DEPTH (wrap-around).
- Pop X: outXValid & outXReady at a rising edge.
  - The read pointer increments modulo DEPTH.
  - outXReady while outXValid=0 is ignored.
- Count update per FIFO:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, with both pointers advancing.
- outXValid = (countX != 0), registered-equivalent. outX = storage[rdptrX].
- Latency: a word pushed at edge N is visible on outX/outXValid after edge N. There is no combinational bypass from inData to outX.
- Throughput: one push per cycle into either FIFO. Both FIFOs may pop in the same cycle.
- Per-output order is FIFO. There is no ordering guarantee between A and B.
- Full, one FIFO: inReady=0 only when inSel points at the full FIFO. Words for the other FIFO still flow.
- Empty: outXValid=0, and outX holds the stale head entry (don't-care for consumers).
- inValid=0: no state change on the input side, regardless of inSel.
- There is no state machine beyond the two count/pointer sets.

Optional Feature:
- Macro: DEMUX32_STATS_EN.
- When defined, adds output ports:
  - cntA (32 bits): total pushes into A.
  - cntB (32 bits): total pushes into B.
  - stallCnt (32 bits): cycles with inValid=1 and inReady=0.
- All three reset to 0, wrap on overflow, and increment on the same edge as the counted event.
- When undefined, none of these ports or registers exist, and behaviour is otherwise identical.

Test Plan:
- Reset behaviour: hold Reset=0 with random inputs, then release. Required:
  - outAValid=outBValid=0 and outA=outB=0.
  - inReady=1 for either inSel.
- Alternating steering: push 0x11111111 (sel 0), 0x22222222 (sel 1), 0x33333333 (sel 0) on consecutive cycles with both readies held 1. Required:
  - outA presents 0x11111111 then 0x33333333.
  - outB presents 0x22222222.
  - Each word appears one cycle after its push, and no words are lost.
- Full FIFO A: outAReady=0, push 3 words with sel=0. Required:
  - The first 2 are accepted; inReady=0 on the third.
  - With sel switched to 1, a push of 0xBBBB0000 is accepted and appears on outB.
- Full FIFO with pop: hold FIFO A full (count 2) with sel=0, inValid=1, outAReady=1 for 1 cycle. Required:
  - inReady=0 that cycle, because there is no pass-through.
  - inReady=1 on the next cycle.
  - The popped word is the oldest.
- Wrap-around: stream 10 words 0..9 to B with outBReady toggling every cycle. Required:
  - outB delivers 0..9 in order.
  - Pointers wrap, and countB never exceeds 2.
- Reset mid-operation: with A holding 2 words and B holding 1, assert Reset for 1 cycle. Required:
  - Both valids drop to 0 immediately (asynchronous).
  - No stale word reappears after release.
  - With DEMUX32_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/demux32_1to2_buf.sv
// demux32_1to2_buf
//   Registered 1-to-2 demultiplexer for 32-bit words. Each accepted input word
//   is steered by inSel into one of two independent FIFOs (A for inSel=0,
//   B for inSel=1). Each FIFO drains through its own valid/ready port, so a
//   stalled consumer only blocks words headed for its own FIFO.
//
// Parameters
//   DEPTH : entries per FIFO (power of two, >= 2)
//   AW    : pointer width, log2(DEPTH)
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   inData     in   word to steer
//   inSel      in   destination select (0 -> A, 1 -> B)
//   inValid    in   producer has a word
//   inReady    out  word accepted this cycle (selected FIFO not full)
//   outA/outB  out  head word of FIFO A / B
//   outAValid  out  FIFO A non-empty
//   outAReady  in   consumer A takes the head
//   outBValid  out  FIFO B non-empty
//   outBReady  in   consumer B takes the head
//
// Optional build macro DEMUX32_STATS_EN adds:
//   cntA, cntB  out  running totals of pushes into A / B
//   stallCnt    out  cycles with inValid=1 and inReady=0
module demux32_1to2_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] inData,
  input  logic        inSel,
  input  logic        inValid,
  output logic        inReady,
  output logic [31:0] outA,
  output logic        outAValid,
  input  logic        outAReady,
  output logic [31:0] outB,
  output logic        outBValid,
  input  logic        outBReady
`ifdef DEMUX32_STATS_EN
  ,
  output logic [31:0] cntA,
  output logic [31:0] cntB,
  output logic [31:0] stallCnt
`endif
);

  localparam logic [AW:0]   FULL_C = DEPTH[AW:0];
  localparam logic [AW:0]   CONE_C = 1;
  localparam logic [AW-1:0] PONE_C = 1;

  logic [31:0]   memA_q [DEPTH];
  logic [31:0]   memB_q [DEPTH];
  logic [AW-1:0] wrA_q, wrA_d, rdA_q, rdA_d;
  logic [AW-1:0] wrB_q, wrB_d, rdB_q, rdB_d;
  logic [AW:0]   countA_q, countA_d, countB_q, countB_d;

  logic pushA, pushB, popA, popB;

  // Readiness looks only at registered occupancy: a full FIFO refuses a word
  // even if its consumer is popping in the same cycle.
  always_comb begin
    inReady   = inSel ? (countB_q != FULL_C) : (countA_q != FULL_C);
    outAValid = (countA_q != '0);
    outBValid = (countB_q != '0);
    outA      = memA_q[rdA_q];
    outB      = memB_q[rdB_q];
    pushA     = inValid & inReady & ~inSel;
    pushB     = inValid & inReady &  inSel;
    popA      = outAValid & outAReady;
    popB      = outBValid & outBReady;
  end

  // Pointers are AW bits wide, so the +1 wraps modulo DEPTH by itself.
  always_comb begin
    wrA_d    = pushA ? wrA_q + PONE_C : wrA_q;
    rdA_d    = popA  ? rdA_q + PONE_C : rdA_q;
    wrB_d    = pushB ? wrB_q + PONE_C : wrB_q;
    rdB_d    = popB  ? rdB_q + PONE_C : rdB_q;
    countA_d = countA_q;
    countB_d = countB_q;
    case ({pushA, popA})
      2'b10:   countA_d = countA_q + CONE_C;
      2'b01:   countA_d = countA_q - CONE_C;
      default: countA_d = countA_q;
    endcase
    case ({pushB, popB})
      2'b10:   countB_d = countB_q + CONE_C;
      2'b01:   countB_d = countB_q - CONE_C;
      default: countB_d = countB_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wrA_q    <= '0;
      rdA_q    <= '0;
      wrB_q    <= '0;
      rdB_q    <= '0;
      countA_q <= '0;
      countB_q <= '0;
    end else begin
      wrA_q    <= wrA_d;
      rdA_q    <= rdA_d;
      wrB_q    <= wrB_d;
      rdB_q    <= rdB_d;
      countA_q <= countA_d;
      countB_q <= countB_d;
    end
  end

  // Storage is cleared on reset so both heads read 0 afterwards.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        memA_q[i] <= '0;
        memB_q[i] <= '0;
      end
    end else begin
      if (pushA) memA_q[wrA_q] <= inData;
      if (pushB) memB_q[wrB_q] <= inData;
    end
  end

`ifdef DEMUX32_STATS_EN
  logic [31:0] cntA_q, cntB_q, stall_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cntA_q  <= '0;
      cntB_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pushA)               cntA_q  <= cntA_q + 32'd1;
      if (pushB)               cntB_q  <= cntB_q + 32'd1;
      if (inValid && !inReady) stall_q <= stall_q + 32'd1;
    end
  end

  assign cntA     = cntA_q;
  assign cntB     = cntB_q;
  assign stallCnt = stall_q;
`endif

endmodule

// File: tb/tb_demux32_1to2_buf.sv
// Testbench for demux32_1to2_buf: directed scenarios plus a random phase,
// all checked against a queue-based model of the two destination FIFOs.
module tb_demux32_1to2_buf;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 1;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] inData;
  logic        inSel, inValid, inReady;
  logic [31:0] outA, outB;
  logic        outAValid, outAReady, outBValid, outBReady;
`ifdef DEMUX32_STATS_EN
  logic [31:0] cntA, cntB, stallCnt;
  logic [31:0] mCntA, mCntB, mStall;
`endif

  demux32_1to2_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .inData(inData), .inSel(inSel),
    .inValid(inValid), .inReady(inReady),
    .outA(outA), .outAValid(outAValid), .outAReady(outAReady),
    .outB(outB), .outBValid(outBValid), .outBReady(outBReady)
`ifdef DEMUX32_STATS_EN
    , .cntA(cntA), .cntB(cntB), .stallCnt(stallCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] qA[$];
  logic [31:0] qB[$];
  logic [31:0] rxB[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qA.delete();
    qB.delete();
`ifdef DEMUX32_STATS_EN
    mCntA = 0; mCntB = 0; mStall = 0;
`endif
  endtask

  // Compare every visible output against the model's current contents.
  task automatic check_outputs(input string tag);
    int occ;
    occ = inSel ? qB.size() : qA.size();
    chk({tag, ".inReady"},   32'(inReady),   32'(occ != DEPTH));
    chk({tag, ".outAValid"}, 32'(outAValid), 32'(qA.size() != 0));
    chk({tag, ".outBValid"}, 32'(outBValid), 32'(qB.size() != 0));
    if (qA.size() != 0) chk({tag, ".outA"}, outA, qA[0]);
    if (qB.size() != 0) chk({tag, ".outB"}, outB, qB[0]);
`ifdef DEMUX32_STATS_EN
    chk({tag, ".cntA"},     cntA,     mCntA);
    chk({tag, ".cntB"},     cntB,     mCntB);
    chk({tag, ".stallCnt"}, stallCnt, mStall);
`endif
  endtask

  // One clock cycle: drive, check at negedge, advance the model at posedge.
  task automatic tick(input logic v, input logic s, input logic [31:0] d,
                      input logic ra, input logic rb, input string tag);
    bit rdy, aV, bV;
    inValid = v; inSel = s; inData = d; outAReady = ra; outBReady = rb;
    @(negedge Clk);
    check_outputs(tag);
    if (outBValid && rb) rxB.push_back(outB);
    rdy = (s ? qB.size() : qA.size()) != DEPTH;
    aV  = qA.size() != 0;
    bV  = qB.size() != 0;
    @(posedge Clk);
    if (ra && aV) void'(qA.pop_front());
    if (rb && bV) void'(qB.pop_front());
    if (v && rdy) begin
      if (s) qB.push_back(d);
      else   qA.push_back(d);
    end
`ifdef DEMUX32_STATS_EN
    if (v && rdy && !s) mCntA++;
    if (v && rdy &&  s) mCntB++;
    if (v && !rdy)      mStall++;
`endif
    #1;
  endtask

  initial begin
    int sent, cyc;
    Reset = 1'b0; inValid = 1'b0; inSel = 1'b0; inData = '0;
    outAReady = 1'b0; outBReady = 1'b0;
    model_clear();

    // Reset held with random inputs
    repeat (4) begin
      @(posedge Clk); #1;
      inValid = 1'($urandom); inSel = 1'($urandom); inData = $urandom;
      outAReady = 1'($urandom); outBReady = 1'($urandom);
      @(negedge Clk);
      chk("rst_hold.outAValid", 32'(outAValid), 32'd0);
      chk("rst_hold.outBValid", 32'(outBValid), 32'd0);
    end
    @(posedge Clk); #1;
    inValid = 1'b0;
    Reset = 1'b1;
    inSel = 1'b0; #1;
    chk("rst.inReady_sel0", 32'(inReady), 32'd1);
    inSel = 1'b1; #1;
    chk("rst.inReady_sel1", 32'(inReady), 32'd1);
    chk("rst.outA", outA, 32'd0);
    chk("rst.outB", outB, 32'd0);
    chk("rst.outAValid", 32'(outAValid), 32'd0);
    chk("rst.outBValid", 32'(outBValid), 32'd0);

    // Alternating steering with both consumers ready
    tick(1, 0, 32'h11111111, 1, 1, "alt0");
    tick(1, 1, 32'h22222222, 1, 1, "alt1");
    tick(1, 0, 32'h33333333, 1, 1, "alt2");
    tick(0, 0, 32'h0,        1, 1, "alt3");
    tick(0, 0, 32'h0,        1, 1, "alt4");

    // Fill A with A stalled; third push refused; B still flows
    tick(1, 0, 32'hA0000001, 0, 0, "fullA0");
    tick(1, 0, 32'hA0000002, 0, 0, "fullA1");
    tick(1, 0, 32'hA0000003, 0, 0, "fullA2");
    chk("fullA.third_refused", 32'(qA.size()), 32'd2);
    tick(1, 1, 32'hBBBB0000, 0, 1, "fullA.pushB");
    tick(0, 1, 32'h0,        0, 1, "fullA.seeB");
    chk("fullA.B_delivered", rxB.size() > 0 ? rxB[rxB.size()-1] : 32'hDEAD, 32'hBBBB0000);

    // Full A popped while a push is offered: no pass-through
    tick(1, 0, 32'hCCCC0001, 1, 0, "fullpop0");
    tick(1, 0, 32'hCCCC0001, 0, 0, "fullpop1");
    tick(0, 0, 32'h0,        1, 0, "fullpop2");
    tick(0, 0, 32'h0,        1, 0, "fullpop3");

    // Wrap-around: 0..9 to B with toggling ready
    rxB.delete();
    sent = 0; cyc = 0;
    while ((sent < 10 || qB.size() != 0) && cyc < 100) begin
      bit acc;
      acc = (sent < 10) && (qB.size() != DEPTH);
      tick(sent < 10, 1, 32'(sent), 0, cyc[0] == 1'b0, "wrap");
      if (acc) sent++;
      cyc++;
    end
    chk("wrap.count", 32'(rxB.size()), 32'd10);
    for (int i = 0; i < 10 && i < rxB.size(); i++)
      chk("wrap.order", rxB[i], 32'(i));

    // Random traffic
    repeat (300)
      tick(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), "rand");
    repeat (4) tick(0, 0, 32'h0, 1, 1, "drain");

    // Reset in the middle of operation
    tick(1, 0, 32'hA1A1A1A1, 0, 0, "mid.fill0");
    tick(1, 0, 32'hA2A2A2A2, 0, 0, "mid.fill1");
    tick(1, 1, 32'hB1B1B1B1, 0, 0, "mid.fill2");
    chk("mid.preA", 32'(outAValid), 32'd1);
    Reset = 1'b0; #1;
    chk("mid.async_outAValid", 32'(outAValid), 32'd0);
    chk("mid.async_outBValid", 32'(outBValid), 32'd0);
    model_clear();
    @(posedge Clk); #1;
    inValid = 1'b0;
    Reset = 1'b1; #1;
    chk("mid.post_outA", outA, 32'd0);
    chk("mid.post_outB", outB, 32'd0);
    tick(0, 0, 32'h0, 1, 1, "mid.after0");
    tick(0, 1, 32'h0, 1, 1, "mid.after1");
    tick(1, 1, 32'h5A5A5A5A, 1, 1, "mid.after2");
    tick(0, 0, 32'h0, 1, 1, "mid.after3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
